md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the MIPS datapath. It sits beside the combinational ALU in the EX stage and executes MULT/MULTU/DIV/DIVU over a fixed number of cycles into the HI/LO register pair. It also services MTHI/MTLO writes. A `busy` output lets the hazard unit stall dependent MFHI/MFLO and further MD instructions.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 4).
- `MUL_CYCLES`, 5, multiply latency in cycles (≥ 1).
- `DIV_CYCLES`, 10, divide latency in cycles (≥ 1).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request strobe, sampled on rising edge.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- `a` in WIDTH: rs operand (dividend / multiplicand / MT source).
- `b` in WIDTH: rt operand (divisor / multiplier).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse in the cycle after HI/LO update.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, internal counter=0, latched operands/op cleared.
- States: IDLE, RUN. Reset → IDLE.
- IDLE, `start`=1, op ∈ {MULT, MULTU, DIV, DIVU}:
  - Latch `a`, `b`, `op`.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, `start`=1, op=MTHI/MTLO: `hi`/`lo` ← `a` on that edge; stay IDLE; `busy` stays 0; no `done`.
- IDLE, `start`=1, op=110/111: no effect.
- RUN: counter decrements each edge. On the edge where it reaches 0:
  - `hi`/`lo` take the result.
  - Go to IDLE; `done`=1 for the following cycle.
- `start` while in RUN is ignored for every op, including MTHI/MTLO. Stalling is the hazard unit's responsibility.
- Inputs `a`/`b`/`op` may change freely during RUN; only latched values are used.
- Multiply: 2·WIDTH-bit product; `hi` = upper half, `lo` = lower half.
  - MULT: two's-complement signed.
  - MULTU: unsigned.
- Divide: `lo` = quotient, `hi` = remainder.
  - DIV: signed, quotient truncated toward zero, remainder has the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero (`b`=0): `lo` = all ones, `hi` = `a`; latency unchanged.
- Signed overflow (DIV, `a` = most negative, `b` = −1): `lo` = `a`, `hi` = 0.
- Implementation may be iterative (shift-add / restoring) or latched combinational. Externally visible latency must be exactly as specified.

## Timing
- `start` accepted at edge T0 → `busy`=1 from T0 through edge T0+N, where N = MUL_CYCLES or DIV_CYCLES.
- `hi`/`lo` hold old values until edge T0+N, then show the result; `busy` falls at the same edge.
- `done`=1 during cycle T0+N to T0+N+1 only.
- Earliest next accepted `start` is edge T0+N. Back-to-back operations have no bubble.
- MTHI/MTLO: visible one edge after sampling.
- `reset` asserted mid-RUN:
  - Operation abandoned; `hi`/`lo`/`busy`/`done` → 0 immediately, asynchronously.
  - No write occurs after deassertion.
- `start` sampled in the same cycle `reset` deasserts: normal acceptance at the next edge.

## Test plan
- MULT a=−3 (0xFFFFFFFD), b=7 → after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 5 cycles; one `done` pulse.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 at edge T0+5.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1) after 10 cycles. DIVU a=7, b=2 → lo=3, hi=1.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5 issued during a running DIV → ignored; hi = remainder at completion. Same MTHI after busy falls → hi=0xA5A5A5A5 next edge, busy stays 0.
- Start MULT, assert `reset` at cycle 2 for 1 cycle → hi=lo=0, busy=0 immediately and no later write. A new DIVU 9/4 then gives lo=2, hi=1 after 10 cycles.

Source files
------------

// File: rtl/md_if.sv
// Request/response bundle between the EX-stage issue logic and the multiply/divide unit.
// The master drives requests; the slave returns busy/done status and the HI/LO registers.
interface md_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Fixed-latency MULT/MULTU/DIV/DIVU unit with MTHI/MTLO writes into HI/LO.
// Operands are latched at issue; the result is produced combinationally and committed when the counter expires.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mag_a, mag_b, mag_q, mag_r;
  logic               sgn_op, neg_q, neg_r;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Result datapath, driven only by the latched operands.
  always_comb begin
    sgn_op = ~op_q[0];
    prod   = {{WIDTH{a_q[WIDTH-1] & sgn_op}}, a_q} * {{WIDTH{b_q[WIDTH-1] & sgn_op}}, b_q};

    neg_r  = sgn_op & a_q[WIDTH-1];
    neg_q  = neg_r ^ (sgn_op & b_q[WIDTH-1]);
    mag_a  = neg_r ? (~a_q + 1'b1) : a_q;
    mag_b  = (sgn_op & b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    mag_q  = '0;
    mag_r  = '0;
    if (b_q != '0) begin
      mag_q = mag_a / mag_b;
      mag_r = mag_a % mag_b;
    end

    if (!op_q[1]) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      // Most-negative / -1 wraps back to the most-negative value with a zero remainder.
      res_hi = neg_r ? (~mag_r + 1'b1) : mag_r;
      res_lo = neg_q ? (~mag_q + 1'b1) : mag_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            a_d     = bus.a;
            b_d     = bus.b;
            op_d    = bus.op;
            cnt_d   = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            state_d = RUN;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
          // The completion edge may accept the next MD op so back-to-back issue has no bubble.
          if (bus.start && !bus.op[2]) begin
            a_d     = bus.a;
            b_d     = bus.b;
            op_d    = bus.op;
            cnt_d   = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit: latency, HI/LO results, MT writes, ignored requests and async reset.
module tb_md_unit;
  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  md_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MUL_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one MD op from a point just after an edge and follow it to completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] ai,
                        input logic [W-1:0] bi, input int n, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input bit inject_mthi);
    int busy_cnt;
    int done_cnt;
    busy_cnt  = 0;
    done_cnt  = 0;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = ai;
    bus.b     = bi;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 3'(o + 3'd1);
    for (int c = 1; c <= n; c++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      if (c == n) begin
        chk({tag, ".hold_hi"}, 64'(bus.hi), 64'(model_hi));
        chk({tag, ".hold_lo"}, 64'(bus.lo), 64'(model_lo));
      end
      if (inject_mthi && c == 2) begin
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'hA5A5_A5A5;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(n));
    chk({tag, ".early_done"}, 64'(done_cnt), 64'd0);
    chk({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, ".lo"}, 64'(bus.lo), 64'(el));
    $display("op %s: hi=%08h lo=%08h", tag, bus.hi, bus.lo);
    model_hi = eh;
    model_lo = el;
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic mt_op(input string tag, input logic [2:0] o, input logic [W-1:0] ai,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = ai;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".done"}, 64'(bus.done), 64'd0);
    chk({tag, ".hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, ".lo"}, 64'(bus.lo), 64'(el));
    $display("op %s: hi=%08h lo=%08h", tag, bus.hi, bus.lo);
    model_hi = eh;
    model_lo = el;
  endtask

  initial begin
    int extra;
    total     = 0;
    bad       = 0;
    model_hi  = '0;
    model_lo  = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.hi", 64'(bus.hi), 64'd0);
    chk("reset.lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mult", 3'b000, 32'hFFFF_FFFD, 32'd7, NM, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", 3'b011, 32'd7, 32'd2, ND, 32'd1, 32'd3, 1'b0);
    run_op("divu_by0", 3'b011, 32'h0000_1234, 32'd0, ND, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_mthi_ign", 3'b010, 32'd100, 32'd7, ND, 32'd2, 32'd14, 1'b1);
    mt_op("mthi", 3'b100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd14);
    mt_op("mtlo", 3'b101, 32'h5A5A_1234, 32'hA5A5_A5A5, 32'h5A5A_1234);
    mt_op("noop", 3'b110, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h5A5A_1234);

    // Abandon a MULT two cycles in with an asynchronous reset pulse.
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 32'd6;
    bus.b     = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid.busy", 64'(bus.busy), 64'd0);
    chk("rst_mid.hi", 64'(bus.hi), 64'd0);
    chk("rst_mid.lo", 64'(bus.lo), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    extra = 0;
    repeat (NM + 2) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1 || bus.done === 1'b1) extra++;
    end
    chk("rst_mid.no_activity", 64'(extra), 64'd0);
    chk("rst_mid.hi_after", 64'(bus.hi), 64'd0);
    chk("rst_mid.lo_after", 64'(bus.lo), 64'd0);
    $display("op rst_mid: hi=%08h lo=%08h busy=%0b", bus.hi, bus.lo, bus.busy);
    model_hi = '0;
    model_lo = '0;
    run_op("divu_post_rst", 3'b011, 32'd9, 32'd4, ND, 32'd1, 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
